// File: rtl/ps2_host_tx_pkg.sv
// ps2_host_tx_pkg
//   Shared constants and types for the PS/2 host transmitter:
//   - ps2_host_state_t : transmitter FSM states
//   - PS2_*_DEF        : default PS/2 timing parameters
//   - us_to_cycles     : microseconds -> clock cycles at a given clock rate
//   - cnt_width        : width of a down-counter that is loaded with (limit - 1)
package ps2_host_tx_pkg;

   typedef enum logic [2:0] {
      IDLE,
      INHIBIT,
      START,
      RELEASE,
      DATA,
      ACK,
      WAIT_IDLE,
      DONE
   } ps2_host_state_t;

   localparam int PS2_CLK_FREQ_HZ_DEF       = 74_250_000;
   localparam int PS2_INHIBIT_US_DEF        = 100;
   localparam int PS2_TIMEOUT_US_DEF        = 15000;
   localparam int PS2_START_HOLD_CYCLES_DEF = 16;

   // Integer MHz first, so 74.25 MHz counts as 74 cycles per microsecond.
   function automatic int us_to_cycles(input int clk_freq_hz, input int us);
      return (clk_freq_hz / 1_000_000) * us;
   endfunction

   function automatic int cnt_width(input int limit);
      return (limit > 1) ? $clog2(limit) : 1;
   endfunction

endpackage

// File: rtl/ps2_line_sync.sv
// ps2_line_sync
//   Two-flop synchronizer for one raw PS/2 line plus falling-edge detect.
//   Ports:
//     clk_in    : system clock
//     rst_n_in  : asynchronous active-low reset (line reads as idle-high)
//     line_in   : raw asynchronous line level
//     level_out : synchronized level
//     fall_out  : one-cycle pulse when the synchronized level goes 1 -> 0
module ps2_line_sync (
   input  logic clk_in,
   input  logic rst_n_in,
   input  logic line_in,
   output logic level_out,
   output logic fall_out
);

   logic meta_q;
   logic sync_q;
   logic prev_q;

   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         meta_q <= 1'b1;
         sync_q <= 1'b1;
         prev_q <= 1'b1;
      end else begin
         meta_q <= line_in;
         sync_q <= meta_q;
         prev_q <= sync_q;
      end
   end

   assign level_out = sync_q;
   assign fall_out  = prev_q & ~sync_q;

endmodule

// File: rtl/ps2_host_tx.sv
// ps2_host_tx
//   Host-to-device PS/2 command transmitter (open-drain line control).
//   Ports:
//     clk_in, rst_n_in                 : system clock, async active-low reset
//     tx_data_in, tx_valid_in          : command byte and request
//     tx_ready_out                     : high only while idle
//     ps2_clk_in, ps2_data_in          : raw PS/2 line levels
//     ps2_clk_oe_out, ps2_data_oe_out  : 1 = pull line low
//     busy_out                         : high whenever not idle
//     done_out                         : one-cycle end-of-transfer pulse
//     ack_err_out, timeout_err_out     : error qualifiers, valid with done_out
//
//   state     | meaning
//   ----------+---------------------------------------------------------
//   IDLE      | lines released, waiting for a request
//   INHIBIT   | clock held low, data released
//   START     | clock and data held low (request-to-send)
//   RELEASE   | clock released, start bit on data, wait first device clock
//   DATA      | shifting data bits, parity, then stop on device clocks
//   ACK       | stop released, sample device ack on next falling edge
//   WAIT_IDLE | wait for both lines to return high
//   DONE      | one-cycle completion pulse with error qualifiers
module ps2_host_tx
   import ps2_host_tx_pkg::*;
#(
   parameter int CLK_FREQ_HZ       = PS2_CLK_FREQ_HZ_DEF,
   parameter int INHIBIT_US        = PS2_INHIBIT_US_DEF,
   parameter int TIMEOUT_US        = PS2_TIMEOUT_US_DEF,
   parameter int START_HOLD_CYCLES = PS2_START_HOLD_CYCLES_DEF
) (
   input  logic       clk_in,
   input  logic       rst_n_in,
   input  logic [7:0] tx_data_in,
   input  logic       tx_valid_in,
   output logic       tx_ready_out,
   input  logic       ps2_clk_in,
   input  logic       ps2_data_in,
   output logic       ps2_clk_oe_out,
   output logic       ps2_data_oe_out,
   output logic       busy_out,
   output logic       done_out,
   output logic       ack_err_out,
   output logic       timeout_err_out
);

   localparam int INHIBIT_CYCLES = us_to_cycles(CLK_FREQ_HZ, INHIBIT_US);
   localparam int TIMEOUT_CYCLES = us_to_cycles(CLK_FREQ_HZ, TIMEOUT_US);
   localparam int PHASE_MAX      = (INHIBIT_CYCLES > START_HOLD_CYCLES) ?
                                   INHIBIT_CYCLES : START_HOLD_CYCLES;
   localparam int PHASE_W        = cnt_width(PHASE_MAX);
   localparam int TMO_W          = cnt_width(TIMEOUT_CYCLES);
   localparam int BIT_W          = $clog2(9);

   localparam logic [PHASE_W-1:0] INHIBIT_LOAD = PHASE_W'(INHIBIT_CYCLES - 1);
   localparam logic [PHASE_W-1:0] START_LOAD   = PHASE_W'(START_HOLD_CYCLES - 1);
   localparam logic [TMO_W-1:0]   TMO_LOAD     = TMO_W'(TIMEOUT_CYCLES - 1);
   localparam logic [BIT_W-1:0]   LAST_BIT     = BIT_W'(8);

   ps2_host_state_t    state;
   logic [PHASE_W-1:0] phase_cnt;
   logic [TMO_W-1:0]   tmo_cnt;
   logic [8:0]         frame_q;
   logic [BIT_W-1:0]   bit_idx;
   logic               ack_pend;

   logic clk_level;
   logic clk_fall;
   logic data_level;
   logic data_fall_unused;
   logic line_active;
   logic tmo_expired;

   ps2_line_sync u_clk_sync (
      .clk_in    (clk_in),
      .rst_n_in  (rst_n_in),
      .line_in   (ps2_clk_in),
      .level_out (clk_level),
      .fall_out  (clk_fall)
   );

   ps2_line_sync u_data_sync (
      .clk_in    (clk_in),
      .rst_n_in  (rst_n_in),
      .line_in   (ps2_data_in),
      .level_out (data_level),
      .fall_out  (data_fall_unused)
   );

   assign line_active = (state == RELEASE) || (state == DATA) ||
                        (state == ACK)     || (state == WAIT_IDLE);
   // A device clock edge in the same cycle always wins over expiry.
   assign tmo_expired = line_active && (tmo_cnt == '0) && !clk_fall;

   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         state           <= IDLE;
         phase_cnt       <= '0;
         tmo_cnt         <= '0;
         frame_q         <= '0;
         bit_idx         <= '0;
         ack_pend        <= 1'b0;
         tx_ready_out    <= 1'b1;
         busy_out        <= 1'b0;
         done_out        <= 1'b0;
         ack_err_out     <= 1'b0;
         timeout_err_out <= 1'b0;
         ps2_clk_oe_out  <= 1'b0;
         ps2_data_oe_out <= 1'b0;
      end else begin
         done_out        <= 1'b0;
         ack_err_out     <= 1'b0;
         timeout_err_out <= 1'b0;

         if (tmo_expired) begin
            state           <= DONE;
            ps2_clk_oe_out  <= 1'b0;
            ps2_data_oe_out <= 1'b0;
            done_out        <= 1'b1;
            timeout_err_out <= 1'b1;
         end else begin
            if (clk_fall) begin
               tmo_cnt <= TMO_LOAD;
            end else if (line_active) begin
               tmo_cnt <= tmo_cnt - 1'b1;
            end

            case (state)
               IDLE: begin
                  if (tx_valid_in) begin
                     frame_q         <= {~^tx_data_in, tx_data_in};
                     ack_pend        <= 1'b0;
                     phase_cnt       <= INHIBIT_LOAD;
                     ps2_clk_oe_out  <= 1'b1;
                     ps2_data_oe_out <= 1'b0;
                     tx_ready_out    <= 1'b0;
                     busy_out        <= 1'b1;
                     state           <= INHIBIT;
                  end
               end
               INHIBIT: begin
                  if (phase_cnt == '0) begin
                     phase_cnt       <= START_LOAD;
                     ps2_data_oe_out <= 1'b1;
                     state           <= START;
                  end else begin
                     phase_cnt <= phase_cnt - 1'b1;
                  end
               end
               START: begin
                  if (phase_cnt == '0) begin
                     tmo_cnt        <= TMO_LOAD;
                     ps2_clk_oe_out <= 1'b0;
                     state          <= RELEASE;
                  end else begin
                     phase_cnt <= phase_cnt - 1'b1;
                  end
               end
               RELEASE: begin
                  if (clk_fall) begin
                     bit_idx         <= '0;
                     ps2_data_oe_out <= ~frame_q[0];
                     state           <= DATA;
                  end
               end
               DATA: begin
                  // frame_q[0] is the bit currently on the line.
                  if (clk_fall) begin
                     if (bit_idx == LAST_BIT) begin
                        ps2_data_oe_out <= 1'b0;
                        state           <= ACK;
                     end else begin
                        bit_idx         <= bit_idx + 1'b1;
                        ps2_data_oe_out <= ~frame_q[1];
                        frame_q         <= {1'b0, frame_q[8:1]};
                     end
                  end
               end
               ACK: begin
                  if (clk_fall) begin
                     ack_pend <= data_level;
                     state    <= WAIT_IDLE;
                  end
               end
               WAIT_IDLE: begin
                  if (clk_level && data_level) begin
                     done_out    <= 1'b1;
                     ack_err_out <= ack_pend;
                     state       <= DONE;
                  end
               end
               DONE: begin
                  tx_ready_out <= 1'b1;
                  busy_out     <= 1'b0;
                  state        <= IDLE;
               end
               default: begin
                  ps2_clk_oe_out  <= 1'b0;
                  ps2_data_oe_out <= 1'b0;
                  tx_ready_out    <= 1'b1;
                  busy_out        <= 1'b0;
                  state           <= IDLE;
               end
            endcase
         end
      end
   end

endmodule
